vreg_writeback: RTL and testbench
=================================

// Module: vreg_writeback
// PURPOSE
//  Write side of the vector register file: opposite end from the operand read path.
//  - Accepts result writebacks from the vector ALU and vector LSU (valid/ready each).
//  - Round-robin arbitrates them into a DEPTH-entry FIFO, then drains the FIFO into the
//    register-file write port.
//  - Keeps a per-vreg pending scoreboard that the issue/operand side uses to stall RAW hazards.
// PARAMETERS
//  NUM_VREGS  64   architectural vector registers; VD_W = $clog2(NUM_VREGS)
//  LANES      32   lanes per vreg; one lane-enable bit each
//  ELEM_W     16   bits per lane; DATA_W = LANES*ELEM_W
//  DEPTH      4    writeback FIFO entries (power of 2, >=2)
// PORTS
//  CLK           in   1          clock, rising edge
//  RST           in   1          synchronous reset, active-high
//  flush         in   1          drop all queued writebacks and pending bits
//  issue_valid   in   1          instruction issued that will write issue_vd
//  issue_vd      in   VD_W       destination vreg of issued instruction
//  alu_wb_valid  in   1          ALU result valid
//  alu_wb_ready  out  1          ALU result accepted this cycle
//  alu_wb_vd     in   VD_W       ALU destination vreg
//  alu_wb_data   in   DATA_W     ALU result
//  alu_wb_lmask  in   LANES      ALU lane write enables
//  lsu_wb_valid/ready/vd/data/lmask   same as alu_wb_*, for LSU
//  vrf_wr_en     out  1          write request to register file
//  vrf_wr_ready  in   1          register file accepts write this cycle
//  vrf_wr_vd     out  VD_W       write destination
//  vrf_wr_data   out  DATA_W     write data
//  vrf_wr_lmask  out  LANES      lane write enables
//  pending       out  NUM_VREGS  bit i=1: vreg i has an outstanding write
//  wb_count      out  16         completed register-file writes, wraps at 2^16
// BEHAVIOUR
//  - Reset (RST=1 at edge): FIFO empty, rr pointer=ALU, pending=0, wb_count=0.
//    Resulting outputs: vrf_wr_en=0, vrf_wr_vd/data/lmask=0, *_wb_ready=0 during reset.
//  - Arbitration:
//    - One source accepted per cycle, only when FIFO count<DEPTH.
//    - Both sources valid: grant goes to the rr pointer's source; the pointer flips to the
//      other source after each accept.
//    - One source valid: it is granted; the pointer is unchanged.
//    - *_wb_ready is combinational: (not full) && (granted).
//  - Full FIFO: no accepts, even if a pop happens in the same cycle (no pass-through when full).
//  - FIFO: entry {vd,data,lmask}; push at tail, pop at head.
//    - vrf_wr_* driven from head; vrf_wr_en = !empty.
//    - Pop on vrf_wr_en && vrf_wr_ready.
//    - Latency: accepted at edge N -> vrf_wr_en visible in the cycle after edge N (1 cycle).
//    - Simultaneous push+pop with count<DEPTH: count unchanged. Pointers wrap mod DEPTH.
//  - vrf_wr_en stays high and vrf_wr_* stay stable while vrf_wr_ready=0 (no drop, no reorder).
//  - Scoreboard:
//    - issue_valid sets pending[issue_vd]; a pop clears pending[vrf_wr_vd].
//    - Same-cycle set of vreg A and clear of vreg B (A!=B): both take effect.
//    - issue_valid to an already-pending vd is illegal; the bench asserts it never happens.
//  - lmask=0 entries are still written and still clear pending (no-op lane write).
//  - wb_count increments by 1 on every pop; wraps 0xFFFF->0.
//  - flush (priority over push, pop, issue):
//    - Next cycle: FIFO empty, pending=0; wb_count and rr pointer unchanged.
//    - *_wb_ready=0 in the flush cycle.
//  - Reset mid-operation discards queued entries; no vrf write issues from the reset cycle on.
// CONFIGURATION
//  VWB_CUT_THROUGH_EN defined:
//    - When the FIFO is empty, vrf_wr_ready=1 and flush=0, the granted source drives vrf_wr_*
//      combinationally in the same cycle (latency 0).
//    - The entry bypasses the FIFO, counts as a pop and clears pending.
//    - If vrf_wr_ready=0, the entry is pushed normally.
//  VWB_CUT_THROUGH_EN undefined: all writes go through the FIFO (latency 1, vrf_wr_* registered).
// TESTING
//  1 Reset: RST high 2 cycles -> vrf_wr_en=0, pending=0, wb_count=0, rr pointer=ALU.
//  2 Single ALU wb vd=5 data=0xA5.. lmask=all-1, vrf_wr_ready=1 -> vrf_wr_en next cycle
//    with vd=5; pending[5] 1->0; wb_count=1.
//  3 ALU+LSU valid together for 4 cycles, vrf_wr_ready=1 -> grants alternate ALU,LSU,ALU,LSU;
//    write order matches grant order.
//  4 vrf_wr_ready=0, 5 ALU wbs offered -> 4 accepted, alu_wb_ready=0 on the 5th.
//    Raise ready -> 4 writes in order, then the 5th is accepted.
//  5 Issue vd=7, ALU wb vd=7 queued, flush -> FIFO empty, pending[7]=0, no vrf write for vd=7.
//  6 wb_count preset near wrap by 65537 writes -> wb_count=1 after wrap.
//    With VWB_CUT_THROUGH_EN: single wb on an empty FIFO -> vrf_wr_en in the same cycle.

Source files
------------

// File: rtl/vreg_writeback_if.sv
//------------------------------------------------------------------------------
// vreg_writeback_if : writeback sources, register-file write port and scoreboard
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vreg_writeback_if #(
  parameter int NUM_VREGS = 64,
  parameter int LANES     = 32,
  parameter int ELEM_W    = 16
);
  localparam int VD_W   = $clog2(NUM_VREGS);
  localparam int DATA_W = LANES * ELEM_W;

  logic                 flush;
  logic                 issue_valid;
  logic [VD_W-1:0]      issue_vd;

  logic                 alu_wb_valid;
  logic                 alu_wb_ready;
  logic [VD_W-1:0]      alu_wb_vd;
  logic [DATA_W-1:0]    alu_wb_data;
  logic [LANES-1:0]     alu_wb_lmask;

  logic                 lsu_wb_valid;
  logic                 lsu_wb_ready;
  logic [VD_W-1:0]      lsu_wb_vd;
  logic [DATA_W-1:0]    lsu_wb_data;
  logic [LANES-1:0]     lsu_wb_lmask;

  logic                 vrf_wr_en;
  logic                 vrf_wr_ready;
  logic [VD_W-1:0]      vrf_wr_vd;
  logic [DATA_W-1:0]    vrf_wr_data;
  logic [LANES-1:0]     vrf_wr_lmask;

  logic [NUM_VREGS-1:0] pending;
  logic [15:0]          wb_count;

  modport slave (
    input  flush, issue_valid, issue_vd,
    input  alu_wb_valid, alu_wb_vd, alu_wb_data, alu_wb_lmask,
    output alu_wb_ready,
    input  lsu_wb_valid, lsu_wb_vd, lsu_wb_data, lsu_wb_lmask,
    output lsu_wb_ready,
    output vrf_wr_en, vrf_wr_vd, vrf_wr_data, vrf_wr_lmask,
    input  vrf_wr_ready,
    output pending, wb_count
  );

  modport master (
    output flush, issue_valid, issue_vd,
    output alu_wb_valid, alu_wb_vd, alu_wb_data, alu_wb_lmask,
    input  alu_wb_ready,
    output lsu_wb_valid, lsu_wb_vd, lsu_wb_data, lsu_wb_lmask,
    input  lsu_wb_ready,
    input  vrf_wr_en, vrf_wr_vd, vrf_wr_data, vrf_wr_lmask,
    output vrf_wr_ready,
    input  pending, wb_count
  );
endinterface

`default_nettype wire

// File: rtl/vreg_writeback.sv
//------------------------------------------------------------------------------
// vreg_writeback : ALU/LSU round-robin writeback into a FIFO feeding the VRF
//                  write port, with a per-vreg pending scoreboard.
// Optional VWB_CUT_THROUGH_EN: granted source bypasses an empty FIFO (latency 0).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vreg_writeback #(
  parameter int NUM_VREGS = 64,
  parameter int LANES     = 32,
  parameter int ELEM_W    = 16,
  parameter int DEPTH     = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  vreg_writeback_if.slave wb
);
  localparam int VD_W   = $clog2(NUM_VREGS);
  localparam int DATA_W = LANES * ELEM_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [VD_W-1:0]      vd_mem_q    [DEPTH];
  logic [DATA_W-1:0]    data_mem_q  [DEPTH];
  logic [LANES-1:0]     lmask_mem_q [DEPTH];
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 rr_q;
  logic [NUM_VREGS-1:0] pending_q, pending_d;
  logic [15:0]          wb_count_q;

  logic                 w_full, w_empty, w_arb_ok;
  logic                 w_both, w_gnt_alu, w_gnt_lsu, w_accept;
  logic                 w_cut, w_push, w_head_vld, w_fifo_pop, w_retire;
  logic [VD_W-1:0]      w_in_vd;
  logic [DATA_W-1:0]    w_in_data;
  logic [LANES-1:0]     w_in_lmask;
  logic [VD_W-1:0]      w_wr_vd;
  logic [DATA_W-1:0]    w_wr_data;
  logic [LANES-1:0]     w_wr_lmask;

  assign w_full   = (count_q == FULL_CNT);
  assign w_empty  = (count_q == '0);
  // A full FIFO refuses even when it pops this cycle: no pass-through.
  assign w_arb_ok = !rst_i && !wb.flush && !w_full;

  // rr_q=0 favours ALU, rr_q=1 favours LSU; only consulted when both request.
  assign w_both    = wb.alu_wb_valid && wb.lsu_wb_valid;
  assign w_gnt_alu = wb.alu_wb_valid && (!wb.lsu_wb_valid || !rr_q);
  assign w_gnt_lsu = wb.lsu_wb_valid && (!wb.alu_wb_valid ||  rr_q);

  assign wb.alu_wb_ready = w_arb_ok && w_gnt_alu;
  assign wb.lsu_wb_ready = w_arb_ok && w_gnt_lsu;
  assign w_accept        = wb.alu_wb_ready || wb.lsu_wb_ready;

  assign w_in_vd    = w_gnt_alu ? wb.alu_wb_vd    : wb.lsu_wb_vd;
  assign w_in_data  = w_gnt_alu ? wb.alu_wb_data  : wb.lsu_wb_data;
  assign w_in_lmask = w_gnt_alu ? wb.alu_wb_lmask : wb.lsu_wb_lmask;

`ifdef VWB_CUT_THROUGH_EN
  assign w_cut = w_accept && w_empty && wb.vrf_wr_ready;
`else
  assign w_cut = 1'b0;
`endif

  assign w_push     = w_accept && !w_cut;
  assign w_head_vld = !w_empty && !rst_i && !wb.flush;
  assign w_fifo_pop = w_head_vld && wb.vrf_wr_ready;
  assign w_retire   = w_fifo_pop || w_cut;

  always_comb begin
    w_wr_vd    = '0;
    w_wr_data  = '0;
    w_wr_lmask = '0;
    if (w_cut) begin
      w_wr_vd    = w_in_vd;
      w_wr_data  = w_in_data;
      w_wr_lmask = w_in_lmask;
    end else if (w_head_vld) begin
      w_wr_vd    = vd_mem_q[head_q];
      w_wr_data  = data_mem_q[head_q];
      w_wr_lmask = lmask_mem_q[head_q];
    end
  end

  assign wb.vrf_wr_en    = w_head_vld || w_cut;
  assign wb.vrf_wr_vd    = w_wr_vd;
  assign wb.vrf_wr_data  = w_wr_data;
  assign wb.vrf_wr_lmask = w_wr_lmask;
  assign wb.pending      = pending_q;
  assign wb.wb_count     = wb_count_q;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Clear before set so a retiring vreg and a newly issued one can share a cycle.
  always_comb begin
    pending_d = pending_q;
    if (w_retire)       pending_d[w_wr_vd]     = 1'b0;
    if (wb.issue_valid) pending_d[wb.issue_vd] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      vd_mem_q[tail_q]    <= w_in_vd;
      data_mem_q[tail_q]  <= w_in_data;
      lmask_mem_q[tail_q] <= w_in_lmask;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rr_q       <= 1'b0;
      pending_q  <= '0;
      wb_count_q <= '0;
    end else if (wb.flush) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      if (w_push)     tail_q <= tail_q + 1'b1;
      if (w_fifo_pop) head_q <= head_q + 1'b1;
      count_q   <= count_d;
      pending_q <= pending_d;
      if (w_accept && w_both) rr_q <= !rr_q;
      if (w_retire) wb_count_q <= wb_count_q + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vreg_writeback.sv
// tb_vreg_writeback : randomized + directed scoreboard bench for vreg_writeback.
`default_nettype none

module tb_vreg_writeback;
  localparam int NUM_VREGS = 64;
  localparam int LANES     = 32;
  localparam int ELEM_W    = 16;
  localparam int DEPTH     = 4;
  localparam int DATA_W    = LANES * ELEM_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vreg_writeback_if #(.NUM_VREGS(NUM_VREGS), .LANES(LANES), .ELEM_W(ELEM_W)) bus ();

  vreg_writeback #(.NUM_VREGS(NUM_VREGS), .LANES(LANES), .ELEM_W(ELEM_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wb   (bus)
  );

  typedef struct {
    logic [5:0]        vd;
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  lmask;
    int                cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_pend = '0;
  logic [15:0] m_cnt  = '0;
  bit          m_favour_lsu = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mon_on = 1'b0;
  bit          stg_rst = 1'b1, stg_flush = 1'b0, stg_iss = 1'b0;
  logic [5:0]  stg_iss_vd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [LANES-1:0] rnd_lmask();
    logic [LANES-1:0] m;
    m = ($urandom_range(0, 7) == 0) ? '0 : LANES'($urandom);
    return m;
  endfunction

  // One cycle: drive, then at negedge predict the grant from the queued-entry count.
  task automatic do_cycle(input bit av, input logic [5:0] avd, input bit lv, input logic [5:0] lvd,
                          input bit rdy, input bit fl, input bit iv, input logic [5:0] ivd,
                          input bit r, output bit alu_acc);
    int   winner;
    exp_t e;
    rst              = r;
    bus.flush        = fl;
    bus.issue_valid  = iv;
    bus.issue_vd     = ivd;
    bus.alu_wb_valid = av;
    bus.alu_wb_vd    = avd;
    bus.alu_wb_data  = rnd_data();
    bus.alu_wb_lmask = rnd_lmask();
    bus.lsu_wb_valid = lv;
    bus.lsu_wb_vd    = lvd;
    bus.lsu_wb_data  = rnd_data();
    bus.lsu_wb_lmask = rnd_lmask();
    bus.vrf_wr_ready = rdy;
    @(negedge clk);
    winner = 0;
    if (!r && !fl && exp_q.size() < DEPTH) begin
      if (av && lv) winner = m_favour_lsu ? 2 : 1;
      else if (av)  winner = 1;
      else if (lv)  winner = 2;
    end
    chk("alu_wb_ready", {511'b0, bus.alu_wb_ready}, {511'b0, winner == 1});
    chk("lsu_wb_ready", {511'b0, bus.lsu_wb_ready}, {511'b0, winner == 2});
    if (winner == 1) begin
      e.vd = avd; e.data = bus.alu_wb_data; e.lmask = bus.alu_wb_lmask; e.cyc = cyc;
      exp_q.push_back(e);
    end else if (winner == 2) begin
      e.vd = lvd; e.data = bus.lsu_wb_data; e.lmask = bus.lsu_wb_lmask; e.cyc = cyc;
      exp_q.push_back(e);
    end
    if (winner != 0 && av && lv) m_favour_lsu = !m_favour_lsu;
    if (r) m_favour_lsu = 1'b0;
    assert (!(iv && !r && !fl && m_pend[ivd])) else $error("FAIL illegal issue to pending vd %0d", ivd);
    stg_rst    = r;
    stg_flush  = fl;
    stg_iss    = iv && !r && !fl;
    stg_iss_vd = ivd;
    alu_acc    = (winner == 1);
    @(posedge clk);
    #1;
  endtask

  function automatic bit vd_busy(input logic [5:0] v);
    foreach (exp_q[i]) if (exp_q[i].vd == v) return 1'b1;
    return m_pend[v];
  endfunction

  // Scoreboard monitor: runs after the stimulus has pushed this cycle's expectations.
  initial begin
    bit exp_en;
    forever begin
      @(negedge clk);
      #1;
      if (mon_on) begin
        chk("pending", {448'b0, bus.pending}, {448'b0, m_pend});
        chk("wb_count", {496'b0, bus.wb_count}, {496'b0, m_cnt});
        exp_en = !stg_rst && !stg_flush && exp_q.size() > 0;
        if (exp_en) begin
`ifdef VWB_CUT_THROUGH_EN
          exp_en = (exp_q[0].cyc < cyc) || bus.vrf_wr_ready;
`else
          exp_en = (exp_q[0].cyc < cyc);
`endif
        end
        chk("vrf_wr_en", {511'b0, bus.vrf_wr_en}, {511'b0, exp_en});
        if (bus.vrf_wr_en && exp_en) begin
          chk("vrf_wr_vd", {506'b0, bus.vrf_wr_vd}, {506'b0, exp_q[0].vd});
          chk("vrf_wr_data", bus.vrf_wr_data, exp_q[0].data);
          chk("vrf_wr_lmask", {480'b0, bus.vrf_wr_lmask}, {480'b0, exp_q[0].lmask});
          if (bus.vrf_wr_ready) begin
            m_pend[exp_q[0].vd] = 1'b0;
            m_cnt = m_cnt + 16'd1;
            void'(exp_q.pop_front());
          end
        end else if (!bus.vrf_wr_en) begin
          chk("idle_vd_lmask", {474'b0, bus.vrf_wr_vd, bus.vrf_wr_lmask}, '0);
        end
        if (stg_rst) begin
          exp_q.delete(); m_pend = '0; m_cnt = '0;
        end else if (stg_flush) begin
          exp_q.delete(); m_pend = '0;
        end else if (stg_iss) begin
          m_pend[stg_iss_vd] = 1'b1;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc;
    bit         av, lv, iv, rdy, fl, r;
    logic [5:0] avd, lvd, ivd;
    int         got;
    bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_vd = '0;
    bus.alu_wb_valid = 1'b0; bus.alu_wb_vd = '0; bus.alu_wb_data = '0; bus.alu_wb_lmask = '0;
    bus.lsu_wb_valid = 1'b0; bus.lsu_wb_vd = '0; bus.lsu_wb_data = '0; bus.lsu_wb_lmask = '0;
    bus.vrf_wr_ready = 1'b0;
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    // Reset held two cycles.
    repeat (2) do_cycle(0, 0, 0, 0, 1, 0, 0, 0, 1, acc);

    // Single ALU writeback to vd 5 after its issue.
    do_cycle(0, 0, 0, 0, 1, 0, 1, 6'd5, 0, acc);
    do_cycle(1, 6'd5, 0, 0, 1, 0, 0, 0, 0, acc);
    repeat (3) do_cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, acc);
    chk("single_wb_count", {496'b0, bus.wb_count}, 512'd1);

    // Both sources requesting: alternating grants starting with ALU.
    for (int i = 0; i < 4; i++) do_cycle(1, 6'(10 + i), 1, 6'(20 + i), 1, 0, 0, 0, 0, acc);
    repeat (4) do_cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, acc);

    // Backpressure: five ALU offers with the write port stalled, then release.
    for (int i = 0; i < 5; i++) do_cycle(1, 6'(30 + i), 0, 0, 0, 0, 0, 0, 0, acc);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      do_cycle(1, 6'd34, 0, 0, 1, 0, 0, 0, 0, acc);
      if (acc) got = 1;
    end
    chk("fifth_accepted", 512'(got), 512'd1);
    repeat (3) do_cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, acc);

    // Flush drops a queued writeback and its pending bit.
    do_cycle(0, 0, 0, 0, 0, 0, 1, 6'd7, 0, acc);
    do_cycle(1, 6'd7, 0, 0, 0, 0, 0, 0, 0, acc);
    do_cycle(0, 0, 0, 0, 1, 1, 0, 0, 0, acc);
    repeat (3) do_cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, acc);

    // Randomized traffic with issues, stalls, flushes and rare resets.
    for (int n = 0; n < 2000; n++) begin
      av  = ($urandom_range(0, 99) < 60);
      lv  = ($urandom_range(0, 99) < 50);
      avd = 6'($urandom_range(0, 63));
      lvd = 6'($urandom_range(0, 63));
      if (m_pend != '0 && $urandom_range(0, 99) < 70) begin
        for (int t = 0; t < 32; t++) begin
          avd = 6'($urandom_range(0, 63));
          if (m_pend[avd]) break;
        end
      end
      rdy = ($urandom_range(0, 99) < 70);
      fl  = ($urandom_range(0, 99) < 2);
      r   = ($urandom_range(0, 999) < 5);
      iv  = 1'b0;
      ivd = '0;
      if ($urandom_range(0, 99) < 30) begin
        for (int t = 0; t < 20 && !iv; t++) begin
          ivd = 6'($urandom_range(0, 63));
          if (!vd_busy(ivd) && ivd != avd && ivd != lvd) iv = 1'b1;
        end
      end
      do_cycle(av, avd, lv, lvd, rdy, fl, iv, ivd, r, acc);
    end

    // Counter wrap: 65537 writes after reset leaves wb_count at 1.
    repeat (2) do_cycle(0, 0, 0, 0, 1, 0, 0, 0, 1, acc);
    got = 0;
    for (int n = 0; n < 70000 && got < 65537; n++) begin
      do_cycle(1, 6'($urandom_range(0, 63)), 0, 0, 1, 0, 0, 0, 0, acc);
      if (acc) got++;
    end
    repeat (4) do_cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, acc);
    chk("wrap_wb_count", {496'b0, bus.wb_count}, 512'd1);

`ifdef VWB_CUT_THROUGH_EN
    // Same-cycle write on an empty FIFO.
    bus.alu_wb_valid = 1'b1; bus.alu_wb_vd = 6'd9; bus.vrf_wr_ready = 1'b1;
    bus.lsu_wb_valid = 1'b0; bus.flush = 1'b0; bus.issue_valid = 1'b0;
    #1;
    chk("cut_through_en", {511'b0, bus.vrf_wr_en}, 512'd1);
    do_cycle(1, 6'd9, 0, 0, 1, 0, 0, 0, 0, acc);
    repeat (2) do_cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, acc);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
